// File: rtl/xfmat2axivideo_tx_if.sv
// Stream-side bundle of the xf::Mat to AXI4-Stream video transmitter.
//  FIFO read side : src_dout, src_empty_n (FWFT head) in; src_read (pop) out
//  AXI4-Stream    : m_axis_tdata/tvalid/tuser/tlast out; m_axis_tready in
// The master modport is the transmitter view; slave is the environment view.
interface xfmat2axivideo_tx_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] src_dout;
    logic              src_empty_n;
    logic              src_read;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tuser;
    logic              m_axis_tlast;

    modport master (
        input  src_dout, src_empty_n, m_axis_tready,
        output src_read, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
    );

    modport slave (
        output src_dout, src_empty_n, m_axis_tready,
        input  src_read, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
    );
endinterface

// File: rtl/xfmat2axivideo_tx.sv
// Drains an FWFT pixel FIFO and emits one frame as AXI4-Stream video
// (tuser = start of frame, tlast = end of line), started by ap_ctrl_hs.
//  clock, reset        : rising-edge clock, synchronous active-high reset
//  ap_start/ap_idle/ap_ready/ap_done : frame-level block handshake
//  rows, cols          : frame size, latched when the frame starts
//  bus (master)        : FIFO read side and AXI4-Stream master
//  axis_block          : combinational, beat stalled by downstream
//  src_block           : combinational, pixels still owed but FIFO empty
module xfmat2axivideo_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ap_start,
    output logic                ap_idle,
    output logic                ap_ready,
    output logic                ap_done,
    input  logic [CNT_W-1:0]    rows,
    input  logic [CNT_W-1:0]    cols,
    xfmat2axivideo_tx_if.master bus,
    output logic                axis_block,
    output logic                src_block
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [CNT_W-1:0]  rows_r;
    logic [CNT_W-1:0]  cols_r;
    logic [CNT_W-1:0]  row_q;
    logic [CNT_W-1:0]  col_q;
    logic              fetch_left;
    logic [DATA_W-1:0] tdata_q;
    logic              tvalid_q;
    logic              tuser_q;
    logic              tlast_q;

    logic              start_go;
    logic              load;
    logic              col_last;
    logic              row_last;

    assign col_last = (col_q == cols_r - CNT_W'(1));
    assign row_last = (row_q == rows_r - CNT_W'(1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; once fetching is finished the held beat is the frame's last one
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ap_start) begin
                    state_nxt = ((rows == CNT_W'(0)) || (cols == CNT_W'(0))) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                if (!fetch_left && tvalid_q && bus.m_axis_tready) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control outputs and register-slice load decode
    always_comb begin
        ap_idle    = 1'b0;
        ap_done    = 1'b0;
        ap_ready   = 1'b0;
        start_go   = 1'b0;
        load       = 1'b0;
        axis_block = 1'b0;
        src_block  = 1'b0;
        case (state)
            S_IDLE: begin
                ap_idle  = 1'b1;
                start_go = ap_start;
            end
            S_STREAM: begin
                load      = fetch_left && bus.src_empty_n && (!tvalid_q || bus.m_axis_tready);
                src_block = fetch_left && !bus.src_empty_n;
            end
            S_DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
            end
            default: ;
        endcase
        axis_block   = tvalid_q && !bus.m_axis_tready;
        bus.src_read = load;
    end

    // Frame counters and the single output register slice
    always_ff @(posedge clock) begin
        if (reset) begin
            rows_r     <= '0;
            cols_r     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            fetch_left <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tuser_q    <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            if (start_go) begin
                rows_r     <= rows;
                cols_r     <= cols;
                row_q      <= '0;
                col_q      <= '0;
                fetch_left <= (rows != CNT_W'(0)) && (cols != CNT_W'(0));
            end
            if (load) begin
                tdata_q  <= bus.src_dout;
                tuser_q  <= (row_q == CNT_W'(0)) && (col_q == CNT_W'(0));
                tlast_q  <= col_last;
                tvalid_q <= 1'b1;
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_q + CNT_W'(1);
                    if (row_last) begin
                        fetch_left <= 1'b0;
                    end
                end else begin
                    col_q <= col_q + CNT_W'(1);
                end
            end else if (bus.m_axis_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tuser  = tuser_q;
    assign bus.m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_xfmat2axivideo_tx.sv
// Bench for xfmat2axivideo_tx: table of frame shapes plus random frames, a
// frame-level reference model (expected beat list from pixel order and the
// row/column shape) and hand-written reset / back-to-back sequences.
`timescale 1ns/1ps
module tb_xfmat2axivideo_tx;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned CNT_W    = 10;
    localparam int          ROWS_MAX = 600;
    localparam int          COLS_MAX = 800;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             ap_start = 1'b0;
    logic             ap_idle, ap_ready, ap_done;
    logic [CNT_W-1:0] rows = '0;
    logic [CNT_W-1:0] cols = '0;
    logic             axis_block, src_block;

    xfmat2axivideo_tx_if #(.DATA_W(DATA_W)) bus ();

    xfmat2axivideo_tx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_idle(ap_idle),
        .ap_ready(ap_ready), .ap_done(ap_done), .rows(rows), .cols(cols),
        .bus(bus), .axis_block(axis_block), .src_block(src_block)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Drive-side state
    bit               reset_drv = 1'b1;
    bit               start_drv = 1'b0;
    logic [CNT_W-1:0] rows_drv = '0;
    logic [CNT_W-1:0] cols_drv = '0;
    int               rdy_mode = 0;
    int               feed_per = 0;
    bit               check_en = 1'b0;
    int               cyc = 0;
    logic [7:0]       fifo[$];
    logic [7:0]       pending[$];
    logic [7:0]       sent[$];
    int               sent_ptr = 0;

    // Reference model state
    bit m_stream = 1'b0, m_done_now = 1'b0;
    int m_r = 0, m_c = 0, m_total = 0, m_fetched = 0, m_beat = 0;
    int start_cyc = -1, done_cyc = -1, done_cnt = 0, beat_cnt = 0, tlast_cnt = 0;
    bit prev_stall = 1'b0, prev_tu = 1'b0, prev_tl = 1'b0;
    logic [7:0] prev_td = '0;

    // Sampled DUT outputs of the last cycle
    logic       s_tv, s_tu, s_tl, s_rd, s_idle, s_done, s_ready;
    logic [7:0] s_td;

    typedef struct {
        int r; int c; int rmode; int fper; bit rnd;
        int exp_beats; int exp_lines; int exp_lat;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // One clock: drive at negedge, sample/check 1ns later, model update before posedge.
    task automatic cycle();
        logic [7:0] v;
        bit idle_m, stall, rdy, hs, done_next;
        int j;
        @(negedge clock);
        reset    = reset_drv;
        ap_start = start_drv;
        rows     = rows_drv;
        cols     = cols_drv;
        if (feed_per > 0 && pending.size() > 0 && (cyc % feed_per) == 0) begin
            v = pending.pop_front();
            fifo.push_back(v);
        end
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = ((cyc % 3) == 0);
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        bus.m_axis_tready = rdy;
        bus.src_empty_n   = (fifo.size() > 0);
        bus.src_dout      = (fifo.size() > 0) ? fifo[0] : 8'h00;
        #1;
        s_tv = bus.m_axis_tvalid; s_td = bus.m_axis_tdata;
        s_tu = bus.m_axis_tuser;  s_tl = bus.m_axis_tlast;
        s_rd = bus.src_read;      s_idle = ap_idle;
        s_done = ap_done;         s_ready = ap_ready;
        idle_m    = !m_stream && !m_done_now;
        stall     = s_tv && !rdy;
        hs        = s_tv && rdy;
        done_next = 1'b0;
        if (check_en) begin
            chk("ap_idle", s_idle, idle_m);
            chk("ap_done", s_done, m_done_now);
            chk("ap_ready", s_ready, m_done_now);
            chk("axis_block", axis_block, stall);
            chk("src_read", s_rd, m_stream && (m_fetched < m_total) && (fifo.size() > 0) && !stall);
            chk("src_block", src_block, m_stream && (m_fetched < m_total) && (fifo.size() == 0));
            if (!m_stream) chk("tvalid_outside_frame", s_tv, 0);
            if (prev_stall) begin
                chk("hold_tvalid", s_tv, 1);
                chk("hold_tdata", s_td, prev_td);
                chk("hold_tuser", s_tu, prev_tu);
                chk("hold_tlast", s_tl, prev_tl);
            end
            if (hs && m_stream) begin
                j = m_beat;
                if (sent_ptr < sent.size()) chk("tdata", s_td, sent[sent_ptr]);
                else fail_now("extra_beat");
                chk("tuser", s_tu, (j == 0));
                chk("tlast", s_tl, ((j % m_c) == (m_c - 1)));
                sent_ptr++;
                m_beat++;
                beat_cnt++;
                if (s_tl) tlast_cnt++;
                if (m_beat == m_total) begin
                    m_stream  = 1'b0;
                    done_next = 1'b1;
                end
            end
            if (s_rd) begin
                if (fifo.size() > 0) v = fifo.pop_front();
                if (m_stream) m_fetched++;
            end
            if (s_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (idle_m && start_drv && !reset_drv) begin
                start_cyc = cyc;
                if (rows_drv == '0 || cols_drv == '0) begin
                    done_next = 1'b1;
                end else begin
                    m_stream = 1'b1; m_r = int'(rows_drv); m_c = int'(cols_drv);
                    m_total = m_r * m_c; m_fetched = 0; m_beat = 0;
                end
            end
        end
        m_done_now = done_next;
        prev_stall = stall; prev_td = s_td; prev_tu = s_tu; prev_tl = s_tl;
        if (reset_drv) begin
            m_stream = 1'b0; m_done_now = 1'b0; prev_stall = 1'b0;
        end
        cyc++;
    endtask

    task automatic load_pixels(input int n, input int fper, input bit rnd, input logic [7:0] base);
        logic [7:0] v;
        fifo.delete(); pending.delete(); sent.delete(); sent_ptr = 0;
        for (int i = 0; i < n; i++) begin
            v = rnd ? 8'($urandom) : 8'(base + 8'(i));
            sent.push_back(v);
            if (fper == 0) fifo.push_back(v); else pending.push_back(v);
        end
        // sentinel: must still be in the FIFO after the frame
        if (fper == 0) fifo.push_back(8'hA5); else pending.push_back(8'hA5);
        feed_per = fper;
        beat_cnt = 0; tlast_cnt = 0; done_cnt = 0; start_cyc = -1; done_cyc = -1;
    endtask

    task automatic run_frame(input int r, input int c, input int rmode, input int fper, input bit rnd,
                             input int abort_after, output int beats, output int lines, output int lat);
        int n;
        int budget;
        bit aborted;
        load_pixels(r * c, fper, rnd, 8'h00);
        rdy_mode  = rmode;
        rows_drv  = CNT_W'(r);
        cols_drv  = CNT_W'(c);
        start_drv = 1'b1;
        cycle();
        start_drv = 1'b0;
        rows_drv  = CNT_W'($urandom);
        cols_drv  = CNT_W'($urandom);
        budget    = 20 * r * c + 20;
        n = 0;
        aborted = 1'b0;
        while (done_cnt == 0 && n < budget && !aborted) begin
            if (abort_after >= 0 && beat_cnt > abort_after) begin
                reset_drv = 1'b1;
                cycle();
                reset_drv = 1'b0;
                aborted = 1'b1;
            end else begin
                cycle();
                n++;
            end
        end
        if (!aborted && done_cnt == 0) fail_now("frame_timeout");
        beats = beat_cnt;
        lines = tlast_cnt;
        lat   = done_cyc - start_cyc;
    endtask

    initial begin
        int b, l, lat, r, c, n, d1;
        vecs[0] = '{3, 4, 0, 0, 1'b0, 12, 3, 14};  // plain 3x4
        vecs[1] = '{3, 4, 1, 0, 1'b0, 12, 3, -1};  // tready 1,0,0
        vecs[2] = '{3, 4, 0, 3, 1'b0, 12, 3, -1};  // FIFO fed every 3 cycles
        vecs[3] = '{1, 5, 0, 0, 1'b1,  5, 1,  7};  // single line
        vecs[4] = '{4, 1, 0, 0, 1'b1,  4, 4,  6};  // single column
        vecs[5] = '{2, 3, 2, 2, 1'b1,  6, 2, -1};  // random tready, slow feed
        vecs[6] = '{0, 5, 0, 0, 1'b0,  0, 0,  1};  // zero rows
        vecs[7] = '{3, 0, 0, 0, 1'b0,  0, 0,  1};  // zero cols

        // Reset
        reset_drv = 1'b1;
        check_en  = 1'b0;
        cycle();
        check_en  = 1'b1;
        cycle();
        reset_drv = 1'b0;
        chk("rst_tvalid", s_tv, 0);
        chk("rst_tuser", s_tu, 0);
        chk("rst_tlast", s_tl, 0);
        chk("rst_tdata", s_td, 0);
        chk("rst_ap_idle", s_idle, 1);
        chk("rst_ap_done", s_done, 0);
        chk("rst_ap_ready", s_ready, 0);
        cycle();

        // Table-driven frames
        for (int k = 0; k < 8; k++) begin
            run_frame(vecs[k].r, vecs[k].c, vecs[k].rmode, vecs[k].fper, vecs[k].rnd, -1, b, l, lat);
            chk($sformatf("v%0d_beats", k), b, vecs[k].exp_beats);
            chk($sformatf("v%0d_lines", k), l, vecs[k].exp_lines);
            if (vecs[k].exp_lat >= 0) chk($sformatf("v%0d_latency", k), lat, vecs[k].exp_lat);
            chk($sformatf("v%0d_fifo_left", k), fifo.size() + pending.size(), 1);
            cycle();
        end

        // Random frames
        for (int k = 0; k < 8; k++) begin
            r = $urandom_range(1, 5);
            c = $urandom_range(1, 8);
            run_frame(r, c, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, -1, b, l, lat);
            chk($sformatf("rnd%0d_beats", k), b, r * c);
            chk($sformatf("rnd%0d_lines", k), l, r);
            chk($sformatf("rnd%0d_fifo_left", k), fifo.size() + pending.size(), 1);
        end

        // Largest legal width and height
        run_frame(2, COLS_MAX, 0, 0, 1'b1, -1, b, l, lat);
        chk("wide_beats", b, 2 * COLS_MAX);
        chk("wide_latency", lat, 2 * COLS_MAX + 2);
        run_frame(ROWS_MAX, 1, 0, 0, 1'b1, -1, b, l, lat);
        chk("tall_lines", l, ROWS_MAX);
        chk("tall_latency", lat, ROWS_MAX + 2);

        // Reset in the middle of a frame, then a fresh 2x2 frame
        run_frame(3, 4, 0, 0, 1'b0, 5, b, l, lat);
        cycle();
        chk("midrst_tvalid", s_tv, 0);
        chk("midrst_ap_idle", s_idle, 1);
        run_frame(2, 2, 0, 0, 1'b1, -1, b, l, lat);
        chk("after_rst_beats", b, 4);
        chk("after_rst_latency", lat, 6);

        // ap_start held over two back-to-back 2x2 frames, size inputs disturbed mid-frame
        load_pixels(8, 0, 1'b0, 8'h40);
        rdy_mode  = 0;
        start_drv = 1'b1;
        rows_drv  = CNT_W'(2);
        cols_drv  = CNT_W'(2);
        cycle();
        rows_drv  = CNT_W'(5);
        cols_drv  = CNT_W'(7);
        cycle(); cycle(); cycle();
        rows_drv  = CNT_W'(2);
        cols_drv  = CNT_W'(2);
        n = 0;
        while (done_cnt < 1 && n < 50) begin cycle(); n++; end
        d1 = done_cyc;
        chk("b2b_frame1_beats", beat_cnt, 4);
        cycle();
        chk("b2b_restart_cycle", start_cyc, d1 + 1);
        start_drv = 1'b0;
        while (done_cnt < 2 && n < 100) begin cycle(); n++; end
        chk("b2b_done_count", done_cnt, 2);
        chk("b2b_beats", beat_cnt, 8);
        chk("b2b_lines", tlast_cnt, 4);
        chk("b2b_fifo_left", fifo.size(), 1);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
